// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access size, FSM state, request owner,
// plus the alignment rule used to reject misaligned accesses.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for stores and lane extraction / sign extension for loads
// on a 32-bit little-endian word memory. Purely combinational.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int I_WIDTH = 32
) (
    input  logic [1:0]         addr_lo,
    input  size_e              size,
    input  logic               zero_ext,
    input  logic [I_WIDTH-1:0] store_data,
    input  logic [I_WIDTH-1:0] load_word,
    output logic [3:0]         byteen,
    output logic [I_WIDTH-1:0] store_lanes,
    output logic [I_WIDTH-1:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        byteen      = 4'b0000;
        store_lanes = store_data;
        case (size)
            SZ_BYTE: begin
                byteen      = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                byteen      = 4'b0011 << addr_lo;
                store_lanes = {2{store_data[15:0]}};
            end
            SZ_WORD: byteen = 4'b1111;
            default: byteen = 4'b0000;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{~zero_ext & load_byte[7]}}, load_byte};
            SZ_HALF: load_data = {{16{~zero_ext & load_half[15]}}, load_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter serialising a/b onto one synchronous-read memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise requester a has fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int I_WIDTH   = 32,
    parameter int IMEM_SIZE = 2**15,
    parameter int ADD_WIDTH = $clog2(IMEM_SIZE >> 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic                 a_we,
    input  logic [31:0]          a_addr,
    input  logic [1:0]           a_size,
    input  logic                 a_unsigned,
    input  logic [I_WIDTH-1:0]   a_wdata,
    output logic                 a_rvalid,
    output logic [I_WIDTH-1:0]   a_rdata,
    output logic                 a_err,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic                 b_we,
    input  logic [31:0]          b_addr,
    input  logic [1:0]           b_size,
    input  logic                 b_unsigned,
    input  logic [I_WIDTH-1:0]   b_wdata,
    output logic                 b_rvalid,
    output logic [I_WIDTH-1:0]   b_rdata,
    output logic                 b_err,
    output logic [ADD_WIDTH-1:0] mem_addr,
    output logic                 mem_cs,
    output logic                 mem_clken,
    output logic                 mem_write,
    output logic [3:0]           mem_byteen,
    output logic [I_WIDTH-1:0]   mem_wdata,
    input  logic [I_WIDTH-1:0]   mem_rdata
);

    state_e             state, state_nxt;
    owner_e             owner;
    logic               grant_a, grant_b, accept;
    logic               req_we, req_uns, req_err;
    logic [31:0]        req_addr;
    size_e              req_size;
    logic [I_WIDTH-1:0] req_wdata, load_q, resp_data;
    logic [3:0]         lane_byteen;
    logic [I_WIDTH-1:0] lane_wdata, lane_rdata;

`ifdef DMEM_ARB_RR_EN
    owner_e rr_ptr;

    // rr_ptr names the requester that wins the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= OWN_A;
        else if (accept)
            rr_ptr <= grant_a ? OWN_B : OWN_A;
    end

    always_comb begin
        grant_a = a_valid && (!b_valid || rr_ptr == OWN_A);
        grant_b = b_valid && !grant_a;
    end
`else
    always_comb begin
        grant_a = a_valid;
        grant_b = b_valid && !a_valid;
    end
`endif

    assign accept = (state == S_IDLE) && (grant_a || grant_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            owner <= OWN_A;
        else if (accept)
            owner <= grant_a ? OWN_A : OWN_B;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_we    <= grant_a ? a_we       : b_we;
            req_addr  <= grant_a ? a_addr     : b_addr;
            req_size  <= size_e'(grant_a ? a_size : b_size);
            req_uns   <= grant_a ? a_unsigned : b_unsigned;
            req_wdata <= grant_a ? a_wdata    : b_wdata;
        end
        if (state == S_WAIT)
            load_q <= lane_rdata;
    end

    assign req_err   = misaligned(req_size, req_addr[1:0]) || (req_addr >= 32'(IMEM_SIZE));
    assign resp_data = (req_we || req_err) ? '0 : load_q;

    dmem_lane #(.I_WIDTH(I_WIDTH)) u_lane (
        .addr_lo     (req_addr[1:0]),
        .size        (req_size),
        .zero_ext    (req_uns),
        .store_data  (req_wdata),
        .load_word   (mem_rdata),
        .byteen      (lane_byteen),
        .store_lanes (lane_wdata),
        .load_data   (lane_rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (req_err || req_we) ? S_RESP : S_WAIT;
            S_WAIT:  state_nxt = S_RESP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Everything outward-facing decodes from state so reset clears it immediately.
    always_comb begin
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        a_rvalid   = 1'b0;
        b_rvalid   = 1'b0;
        a_err      = 1'b0;
        b_err      = 1'b0;
        a_rdata    = '0;
        b_rdata    = '0;
        mem_cs     = 1'b0;
        mem_clken  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_byteen = 4'b0000;
        mem_wdata  = '0;
        case (state)
            S_IDLE: begin
                a_ready = grant_a && !rst;
                b_ready = grant_b && !rst;
            end
            S_ISSUE: begin
                if (!req_err) begin
                    mem_cs     = 1'b1;
                    mem_clken  = 1'b1;
                    mem_write  = req_we;
                    mem_addr   = req_addr[ADD_WIDTH+1:2];
                    mem_byteen = lane_byteen;
                    mem_wdata  = req_we ? lane_wdata : '0;
                end
            end
            S_RESP: begin
                if (owner == OWN_A) begin
                    a_rvalid = 1'b1;
                    a_err    = req_err;
                    a_rdata  = resp_data;
                end else begin
                    b_rvalid = 1'b1;
                    b_err    = req_err;
                    b_rdata  = resp_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected memory accesses
// and responses; a monitor forked alongside pops and compares them on the falling edge.
module tb_dmem_arbiter;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid, a_ready, a_we, a_unsigned, a_rvalid, a_err;
    logic [31:0]   a_addr, a_wdata, a_rdata;
    logic [1:0]    a_size;
    logic          b_valid, b_ready, b_we, b_unsigned, b_rvalid, b_err;
    logic [31:0]   b_addr, b_wdata, b_rdata;
    logic [1:0]    b_size;
    logic [AW-1:0] mem_addr;
    logic          mem_cs, mem_clken, mem_write;
    logic [3:0]    mem_byteen;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_size(a_size),
        .a_unsigned(a_unsigned), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_size(b_size),
        .b_unsigned(b_unsigned), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_clken(mem_clken), .mem_write(mem_write),
        .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct { logic own; logic [31:0] rdata; logic err; int cyc; } resp_t;
    typedef struct { logic we; logic [AW-1:0] addr; logic [3:0] be; logic [31:0] wd; int cyc; } acc_t;

    resp_t       exp_q[$];
    acc_t        acc_q[$];
    logic        grant_log[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] mem [0:8191] = '{default: '0};
    logic [31:0] mem_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_cs && mem_clken) begin
            mem_w = mem[mem_addr];
            if (mem_write)
                for (int i = 0; i < 4; i++)
                    if (mem_byteen[i]) mem_w[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_addr] <= mem_w;
            mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        resp_t e;
        acc_t  m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_cs) begin
                    if (acc_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL mem_access: unexpected access addr %h write %b", mem_addr, mem_write);
                    end else begin
                        m = acc_q.pop_front();
                        chk("mem_cycle", cyc, m.cyc);
                        chk("mem_clken", {31'd0, mem_clken}, 32'd1);
                        chk("mem_write", {31'd0, mem_write}, {31'd0, m.we});
                        chk("mem_addr", {19'd0, mem_addr}, {19'd0, m.addr});
                        if (m.we) begin
                            chk("mem_byteen", {28'd0, mem_byteen}, {28'd0, m.be});
                            chk("mem_wdata", mem_wdata, m.wd);
                        end
                    end
                end else if (mem_write || mem_clken) begin
                    n_cmp++; n_fail++;
                    $display("FAIL mem_idle: write %b clken %b without cs", mem_write, mem_clken);
                end
                if (a_rvalid || b_rvalid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL rsp_unexpected: a_rvalid %b b_rvalid %b", a_rvalid, b_rvalid);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_owner", {31'd0, b_rvalid}, {31'd0, e.own});
                        chk("rsp_single", {31'd0, a_rvalid & b_rvalid}, 32'd0);
                        chk("rsp_cycle", cyc, e.cyc);
                        chk("rsp_rdata", e.own ? b_rdata : a_rdata, e.rdata);
                        chk("rsp_err", {31'd0, e.own ? b_err : a_err}, {31'd0, e.err});
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
        bit got = 0;
        if (port) begin
            b_valid = 1; b_we = we; b_addr = addr; b_size = size; b_unsigned = uns; b_wdata = wd;
        end else begin
            a_valid = 1; a_we = we; a_addr = addr; a_size = size; a_unsigned = uns; a_wdata = wd;
        end
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (port ? b_ready : a_ready) got = 1;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout: port %0d addr %h never accepted", port, addr);
        end else begin
            if (!exp_err)
                acc_q.push_back('{we: we, addr: addr[AW+1:2], be: exp_be, wd: exp_wd, cyc: cyc + 1});
            exp_q.push_back('{own: port, rdata: exp_rd, err: exp_err, cyc: cyc + ((we || exp_err) ? 2 : 3)});
            grant_log.push_back(port);
            @(posedge clk);
        end
        #1;
        if (port) b_valid = 0; else a_valid = 0;
    endtask

    initial begin
        bit got;
        logic [2:0] order, exp_order;
        a_valid = 1; a_we = 0; a_addr = 0; a_size = 0; a_unsigned = 0; a_wdata = 0;
        b_valid = 1; b_we = 0; b_addr = 0; b_size = 0; b_unsigned = 0; b_wdata = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        chk("rst_err", {30'd0, a_err, b_err}, 32'd0);
        chk("rst_mem_ctl", {29'd0, mem_cs, mem_clken, mem_write}, 32'd0);
        chk("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
        chk("rst_mem_byteen", {28'd0, mem_byteen}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", a_rdata | b_rdata, 32'd0);
        a_valid = 0; b_valid = 0;
        @(posedge clk); #1 rst = 0;
        fork monitor(); join_none

        //    port we addr          sz uns wdata         exp_rd        err be       exp_wd
        issue(0, 1, 32'h0000_0010, 2, 0, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF);
        issue(0, 0, 32'h0000_0010, 2, 0, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0);
        issue(1, 1, 32'h0000_0013, 0, 0, 32'h0000_0080, 32'h0,       0, 4'b1000, 32'h80808080);
        issue(0, 0, 32'h0000_0013, 0, 0, 32'h0,        32'hFFFFFF80, 0, 4'b0000, 32'h0);
        issue(1, 0, 32'h0000_0013, 0, 1, 32'h0,        32'h00000080, 0, 4'b0000, 32'h0);
        issue(0, 1, 32'h0000_0012, 1, 0, 32'h0000_1234, 32'h0,       0, 4'b1100, 32'h12341234);
        issue(1, 0, 32'h0000_0012, 1, 0, 32'h0,        32'h00001234, 0, 4'b0000, 32'h0);
        issue(0, 0, 32'h0000_0010, 1, 0, 32'h0,        32'hFFFFBEEF, 0, 4'b0000, 32'h0);
        issue(1, 0, 32'h0000_0011, 0, 1, 32'h0,        32'h000000BE, 0, 4'b0000, 32'h0);
        issue(0, 0, 32'h0000_0010, 0, 0, 32'h0,        32'hFFFFFFEF, 0, 4'b0000, 32'h0);
        issue(0, 0, 32'h0000_7FFC, 2, 0, 32'h0,        32'h0,        0, 4'b0000, 32'h0);
        issue(0, 0, 32'h0000_0011, 1, 0, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
        issue(0, 1, 32'h0000_0010, 3, 0, 32'h5555AAAA, 32'h0,        1, 4'b0000, 32'h0);
        issue(0, 0, 32'h0000_0010, 2, 0, 32'h0,        32'h1234BEEF, 0, 4'b0000, 32'h0);
        issue(1, 0, 32'h0000_8000, 2, 0, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
        issue(1, 1, 32'h0000_8004, 2, 0, 32'h11111111, 32'h0,        1, 4'b0000, 32'h0);

        grant_log.delete();
        @(posedge clk); #1;
        fork
            begin
                issue(0, 0, 32'h0000_0010, 2, 0, 32'h0, 32'h1234BEEF, 0, 4'b0000, 32'h0);
                issue(0, 0, 32'h0000_0012, 0, 1, 32'h0, 32'h00000034, 0, 4'b0000, 32'h0);
            end
            issue(1, 0, 32'h0000_0010, 1, 1, 32'h0, 32'h0000BEEF, 0, 4'b0000, 32'h0);
        join
        order = 3'b111;
        if (grant_log.size() == 3) order = {grant_log[0], grant_log[1], grant_log[2]};
`ifdef DMEM_ARB_RR_EN
        exp_order = 3'b010;
`else
        exp_order = 3'b001;
`endif
        chk("grant_order", {29'd0, order}, {29'd0, exp_order});

        // Load interrupted by reset while waiting for memory data.
        a_valid = 1; a_we = 0; a_addr = 32'h10; a_size = 2; a_unsigned = 0;
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (a_ready) got = 1;
        end
        chk("rst_load_accepted", {31'd0, got}, 32'd1);
        if (got) acc_q.push_back('{we: 1'b0, addr: 13'd4, be: 4'd0, wd: 32'd0, cyc: cyc + 1});
        @(posedge clk); #1 a_valid = 0;
        @(posedge clk); #2;
        rst = 1; a_valid = 1;
        #1;
        chk("midrst_ready", {31'd0, a_ready}, 32'd0);
        chk("midrst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        chk("midrst_rdata", a_rdata, 32'd0);
        chk("midrst_mem_cs", {31'd0, mem_cs}, 32'd0);
        a_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (6) @(negedge clk);
        chk("midrst_no_resp", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        issue(0, 1, 32'h0000_0020, 2, 0, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D);
        issue(1, 0, 32'h0000_0020, 2, 0, 32'h0,        32'hCAFEF00D, 0, 4'b0000, 32'h0);
        issue(1, 0, 32'h0000_0021, 0, 0, 32'h0,        32'hFFFFFFF0, 0, 4'b0000, 32'h0);

        for (int n = 0; n < 50 && (exp_q.size() != 0 || acc_q.size() != 0); n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_resp", exp_q.size(), 32'd0);
        chk("drain_mem", acc_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter I_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter IMEM_SIZE, default 2**15, memory size in bytes.
REQ-003 SHALL have parameter ADD_WIDTH, default $clog2(IMEM_SIZE>>2), memory word-address width.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports, per requester p in {a,b}: p_valid in 1 request; p_ready out 1 accept; p_we in 1 store; p_addr in 32 byte address; p_size in 2 (0 byte, 1 half, 2 word); p_unsigned in 1 zero-extend load; p_wdata in I_WIDTH store data; p_rvalid out 1 response pulse; p_rdata out I_WIDTH load data; p_err out 1 access error.
REQ-006 SHALL have memory ports: mem_addr out ADD_WIDTH word address; mem_cs out 1 chipselect; mem_clken out 1 clock enable; mem_write out 1; mem_byteen out 4; mem_wdata out I_WIDTH; mem_rdata in I_WIDTH, valid one cycle after a read issue.

Function
REQ-007 SHALL use FSM states IDLE, ISSUE, WAIT, RESP; p_ready high only in IDLE, and only for the arbitration winner.
REQ-008 SHALL, in IDLE with any valid, grant one requester, register its request and owner id, move to ISSUE (handshake cycle T).
REQ-009 SHALL, in ISSUE (T+1), assert mem_cs=mem_clken=1 for exactly one cycle with mem_addr=addr[ADD_WIDTH+1:2]; store -> RESP, load -> WAIT.
REQ-010 SHALL, in WAIT (T+2), capture mem_rdata, then go to RESP.
REQ-011 SHALL, in RESP, pulse owner's rvalid for one cycle (load T+3, store T+2), then return to IDLE; the other rvalid stays 0.
REQ-012 SHALL drive byteen/wdata for stores: byte -> 1<<addr[1:0], data replicated 4x; half -> 4'b0011<<addr[1:0], data replicated 2x; word -> 4'b1111.
REQ-013 SHALL extract load data by addr[1:0] and size, sign-extending unless unsigned; word loads pass through.
REQ-014 SHALL flag error (half with addr[0]=1, word with addr[1:0]!=0, size=3, or addr>=IMEM_SIZE): no memory access in ISSUE (mem_cs=0), go directly to RESP, rvalid=1 with err=1, rdata=0.
REQ-015 SHALL hold mem_cs, mem_clken, mem_write low outside ISSUE; mem_write=we in ISSUE.
REQ-016 SHALL ignore valid changes during non-IDLE states; a requester keeps valid until its ready.
REQ-017 SHALL default to fixed priority: a wins when both valid.

Reset
REQ-018 SHALL on rst asynchronously force IDLE, all ready/rvalid/err/mem_cs/mem_clken/mem_write to 0, rdata/mem_addr/mem_wdata/mem_byteen to 0, round-robin pointer to a.
REQ-019 SHALL, on reset mid-transaction, drop the in-flight request with no response and no memory write after reset release.

Configuration
REQ-020 SHALL, with DMEM_ARB_RR_EN defined, arbitrate round-robin: on simultaneous valid the requester not granted last wins; pointer updates on each grant.
REQ-021 SHALL, without DMEM_ARB_RR_EN, use fixed priority per REQ-017 and contain no pointer flop.

Structure
REQ-022 SHALL place size encoding enum, FSM state enum and owner enum in shared package dmem_pkg.
REQ-023 SHALL implement store lane steering and load extraction in sub-module dmem_lane (combinational, used for both paths).

Verification
REQ-024 Word store a addr 0x10 data 0xDEADBEEF, then load word -> mem_byteen 1111, a_rvalid at T+3, a_rdata 0xDEADBEEF.
REQ-025 Byte store 0x80 at 0x13, load signed byte 0x13 -> byteen 1000, rdata 0xFFFFFF80; unsigned load -> 0x00000080.
REQ-026 a and b valid same cycle, twice -> fixed: a,a-then-b; with DMEM_ARB_RR_EN: a then b; each rvalid to correct owner only.
REQ-027 Half load at 0x11 and word load at 0x8000 -> no mem_cs, err=1 at T+2, rdata 0.
REQ-028 rst asserted in WAIT of a load -> outputs zero immediately, no rvalid after release, next request served normally.
